// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: sequential word fetches into a DEPTH-entry prefetch FIFO, drained by decode over valid/ready.
// Optional feature macro IFQ_BYPASS_EN: an empty FIFO forwards a fresh fetch response straight to decode in the same cycle.
module ifetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            nrst,
    output logic            imem_ren,
    output logic [XLEN-1:0] imem_addr,
    input  logic            ihit,
    input  logic [XLEN-1:0] imem_load,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_addr,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready
);
    localparam int              AW  = $clog2(DEPTH);
    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t          state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [XLEN-1:0] inst_mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;

    logic [XLEN-1:0] target;
    logic            fifo_empty;
    logic            byp_valid;
    logic            resp_ok;
    logic            push;
    logic            pop;
    logic [AW:0]     count_after;
    logic            space_next;
    logic            unused_bits;

    assign target      = {redirect_addr[XLEN-1:2], 2'b00};
    assign unused_bits = ^redirect_addr[1:0];
    assign fifo_empty  = (count == '0);
    assign resp_ok     = (state == REQ) && ihit && !redirect_en;

`ifdef IFQ_BYPASS_EN
    assign byp_valid = fifo_empty && resp_ok;
`else
    assign byp_valid = 1'b0;
`endif

    // A bypassed word that decode takes immediately never occupies a FIFO slot.
    assign push        = resp_ok && !(byp_valid && inst_ready);
    assign pop         = !fifo_empty && inst_ready && !redirect_en;
    assign count_after = count + (AW+1)'(push) - (AW+1)'(pop);
    assign space_next  = count_after < (AW+1)'(DEPTH);

    assign imem_ren   = (state != IDLE);
    assign imem_addr  = req_addr;
    assign inst_valid = !fifo_empty || byp_valid;

    always_comb begin
        inst    = NOP;
        inst_pc = '0;
        if (!fifo_empty) begin
            inst    = inst_mem[rd_ptr];
            inst_pc = pc_mem[rd_ptr];
        end else if (byp_valid) begin
            inst    = imem_load;
            inst_pc = req_addr;
        end
    end

    // req_addr stays frozen while a request is outstanding, even if a redirect
    // retargets fetch_pc during DROP; the new target is issued only after ihit.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect_en) begin
                        fetch_pc <= target;
                        req_addr <= target;
                        state    <= REQ;
                    end else if (count < (AW+1)'(DEPTH)) begin
                        req_addr <= fetch_pc;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (redirect_en) begin
                        fetch_pc <= target;
                        if (ihit) begin
                            req_addr <= target;
                            state    <= REQ;
                        end else begin
                            state <= DROP;
                        end
                    end else if (ihit) begin
                        fetch_pc <= fetch_pc + XLEN'(4);
                        if (space_next) begin
                            req_addr <= fetch_pc + XLEN'(4);
                            state    <= REQ;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DROP: begin
                    if (redirect_en) begin
                        fetch_pc <= target;
                    end
                    if (ihit) begin
                        req_addr <= redirect_en ? target : fetch_pc;
                        state    <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect_en) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_after;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= req_addr;
            inst_mem[wr_ptr] <= imem_load;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: random memory latency, backpressure and redirects checked against a sequential-PC stream model.
module tb_ifetch_queue;
    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IFQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        imem_ren;
    logic [31:0] imem_addr;
    logic        ihit = 1'b0;
    logic [31:0] imem_load = '0;
    logic        redirect_en = 1'b0;
    logic [31:0] redirect_addr = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;

    always #5 clk = ~clk;

    ifetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .nrst(nrst),
        .imem_ren(imem_ren), .imem_addr(imem_addr),
        .ihit(ihit), .imem_load(imem_load),
        .redirect_en(redirect_en), .redirect_addr(redirect_addr),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_ready(inst_ready)
    );

    int total = 0;
    int bad = 0;
    int hit_cnt = 0;
    int pop_cnt = 0;
    int hit_mode = 0;
    int base;
    logic [63:0] exp_q[$];
    logic [63:0] e;
    logic [31:0] gen_pc = '0;
    logic [31:0] held_addr;

    logic        p_valid = 1'b0, p_ready = 1'b0, p_redir = 1'b0;
    logic        p_ren = 1'b0, p_hit = 1'b0, p_nrst = 1'b0;
    logic [31:0] p_inst = '0, p_pc = '0, p_addr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Decode must see an unbroken run of word addresses from the latest reset or redirect target.
    function automatic void top_up();
        while (exp_q.size() < 8) begin
            exp_q.push_back({gen_pc, mem_word(gen_pc)});
            gen_pc += 32'd4;
        end
    endfunction

    function automatic void restart_stream(input logic [31:0] a);
        exp_q.delete();
        gen_pc = {a[31:2], 2'b00};
        top_up();
    endfunction

    task automatic step();
        @(negedge clk);
        top_up();
    endtask

    task automatic apply_stimulus(input logic [31:0] a);
        redirect_en   = 1'b1;
        redirect_addr = a;
        restart_stream(a);
    endtask

    task automatic apply_reset();
        step();
        nrst        = 1'b0;
        redirect_en = 1'b0;
        restart_stream(32'h0);
        repeat (2) step();
        #2;
        check_output("rst_ren", imem_ren, 0);
        check_output("rst_addr", imem_addr, 32'h0);
        check_output("rst_valid", inst_valid, 0);
        check_output("rst_inst", inst, NOP);
        check_output("rst_pc", inst_pc, 32'h0);
        step();
        nrst = 1'b1;
    endtask

    // Memory responder: completes the outstanding request according to hit_mode.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            ihit = imem_ren && nrst &&
                   (hit_mode == 1 || (hit_mode == 2 && $urandom_range(0, 2) != 0));
            imem_load = ihit ? mem_word(imem_addr) : 32'hDEAD_BEEF;
            if (ihit) hit_cnt++;
        end
    end

    // Monitor: protocol checks plus scoreboard pop on every accepted instruction.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (nrst) begin
                if (!inst_valid) begin
                    check_output("idle_inst", inst, NOP);
                    check_output("idle_pc", inst_pc, 32'h0);
                end
                if (p_nrst && p_valid && !p_ready && !p_redir) begin
                    check_output("hold_valid", inst_valid, 1);
                    check_output("hold_inst", inst, p_inst);
                    check_output("hold_pc", inst_pc, p_pc);
                end
                if (p_nrst && p_ren && !p_hit) begin
                    check_output("hold_ren", imem_ren, 1);
                    check_output("hold_addr", imem_addr, p_addr);
                end
                if (p_nrst && p_redir && !(BYP && ihit)) begin
                    check_output("flush_valid", inst_valid, 0);
                end
                if (inst_valid && inst_ready && !redirect_en) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL pop_unexpected: got pc %h, scoreboard required none", inst_pc);
                    end else begin
                        e = exp_q.pop_front();
                        check_output("pop_pc", inst_pc, e[63:32]);
                        check_output("pop_inst", inst, e[31:0]);
                        pop_cnt++;
                    end
                end
            end
            p_valid = inst_valid;
            p_ready = inst_ready;
            p_redir = redirect_en;
            p_ren   = imem_ren;
            p_hit   = ihit;
            p_nrst  = nrst;
            p_inst  = inst;
            p_pc    = inst_pc;
            p_addr  = imem_addr;
        end
    end

    initial begin
        // Reset, then a continuous stream with decode always ready.
        apply_reset();
        hit_mode   = 1;
        inst_ready = 1'b1;
        #2;
        check_output("first_ren_wait", imem_ren, 0);
        step();
        #2;
        check_output("first_ren", imem_ren, 1);
        check_output("first_addr", imem_addr, 32'h0);
        check_output("first_valid", inst_valid, BYP);
        if (!BYP) begin
            step();
            #2;
        end
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                step();
                #2;
            end
            check_output("stream_valid", inst_valid, 1);
            check_output("stream_pc", inst_pc, 32'(4 * i));
            check_output("stream_inst", inst, mem_word(32'(4 * i)));
        end

        // Backpressure: exactly DEPTH fetches, then the fetcher idles.
        apply_reset();
        inst_ready = 1'b0;
        hit_mode   = 1;
        hit_cnt    = 0;
        repeat (10) step();
        #2;
        check_output("bp_hits", 32'(hit_cnt), 32'd4);
        check_output("bp_ren", imem_ren, 0);
        check_output("bp_valid", inst_valid, 1);
        check_output("bp_pc", inst_pc, 32'h0);
        check_output("bp_inst", inst, mem_word(32'h0));
        step();
        inst_ready = 1'b1;
        base = pop_cnt;
        repeat (8) step();
        check_output("bp_resume_pops", 32'(pop_cnt - base), 32'd8);

        // Redirect while a request is outstanding; that response is dropped.
        inst_ready = 1'b0;
        hit_mode   = 0;
        step();
        #2;
        held_addr = imem_addr;
        check_output("rd_pre_ren", imem_ren, 1);
        step();
        apply_stimulus(32'h0000_0103);
        step();
        redirect_en = 1'b0;
        #2;
        check_output("rd_flush_valid", inst_valid, 0);
        check_output("rd_hold_ren", imem_ren, 1);
        check_output("rd_hold_addr", imem_addr, held_addr);
        step();
        hit_mode = 1;
        step();
        #2;
        check_output("rd_new_addr", imem_addr, 32'h0000_0100);
        step();
        #2;
        check_output("rd_head_valid", inst_valid, 1);
        check_output("rd_head_pc", inst_pc, 32'h0000_0100);

        // Address wrap at the top of the address space.
        step();
        apply_stimulus(32'hFFFF_FFFC);
        step();
        redirect_en = 1'b0;
        repeat (4) step();
        #2;
        check_output("wrap_pc0", inst_pc, 32'hFFFF_FFFC);
        check_output("wrap_inst0", inst, mem_word(32'hFFFF_FFFC));
        step();
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        #2;
        check_output("wrap_pc1", inst_pc, 32'h0);
        check_output("wrap_inst1", inst, mem_word(32'h0));

        // Asynchronous reset while a request is in flight.
        step();
        hit_mode = 0;
        apply_stimulus(32'h0000_0200);
        step();
        redirect_en = 1'b0;
        step();
        #2;
        check_output("mid_pre_ren", imem_ren, 1);
        step();
        nrst = 1'b0;
        restart_stream(32'h0);
        #1;
        check_output("mid_ren", imem_ren, 0);
        check_output("mid_addr", imem_addr, 32'h0);
        check_output("mid_valid", inst_valid, 0);
        check_output("mid_inst", inst, NOP);
        check_output("mid_pc", inst_pc, 32'h0);
        step();
        step();
        nrst = 1'b1;

        // Random latency, backpressure and redirects.
        hit_mode = 2;
        for (int c = 0; c < 1500; c++) begin
            step();
            inst_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) begin
                if ($urandom_range(0, 3) == 0)
                    apply_stimulus(32'hFFFF_FFF0 + 32'($urandom_range(0, 15)));
                else
                    apply_stimulus($urandom());
            end else begin
                redirect_en = 1'b0;
            end
        end
        step();
        redirect_en = 1'b0;
        inst_ready  = 1'b1;
        repeat (10) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
